// File: rtl/lcd_pkg.sv
// Shared ILI9341 command codes, panel geometry and the rectangle-fill state encoding.
package lcd_pkg;

  localparam logic [7:0]  ILI_CASET = 8'h2A;
  localparam logic [7:0]  ILI_PASET = 8'h2B;
  localparam logic [7:0]  ILI_RAMWR = 8'h2C;
  localparam logic [15:0] COLOR_RED = 16'hF800;

  localparam int LCD_W = 320;
  localparam int LCD_H = 240;

  // Byte states are numbered in transmit order so the sequencer can step by +1.
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    S_CASET = 4'd1,
    XS_H    = 4'd2,
    XS_L    = 4'd3,
    XE_H    = 4'd4,
    XE_L    = 4'd5,
    S_PASET = 4'd6,
    YS_H    = 4'd7,
    YS_L    = 4'd8,
    YE_H    = 4'd9,
    YE_L    = 4'd10,
    S_RAMWR = 4'd11,
    PIX_H   = 4'd12,
    PIX_L   = 4'd13
  } fill_state_t;

  function automatic logic [7:0] hi_byte(input logic [15:0] v);
    return v[15:8];
  endfunction

  function automatic logic [7:0] lo_byte(input logic [15:0] v);
    return v[7:0];
  endfunction

endpackage

// File: rtl/lcd_rect_fill_seq_rect_norm.sv
// Combinational rectangle normaliser: clamp to the panel, order each pair, count pixels.
module rect_norm #(
  parameter int X_W   = 9,
  parameter int Y_W   = 9,
  parameter int MAX_X = 319,
  parameter int MAX_Y = 239,
  parameter int CNT_W = 17
) (
  input  logic [X_W-1:0]   x0,
  input  logic [X_W-1:0]   x1,
  input  logic [Y_W-1:0]   y0,
  input  logic [Y_W-1:0]   y1,
  output logic [X_W-1:0]   xs,
  output logic [X_W-1:0]   xe,
  output logic [Y_W-1:0]   ys,
  output logic [Y_W-1:0]   ye,
  output logic [CNT_W-1:0] pix_cnt
);

  localparam logic [X_W-1:0] MX = X_W'(MAX_X);
  localparam logic [Y_W-1:0] MY = Y_W'(MAX_Y);

  logic [X_W-1:0]   xa, xb;
  logic [Y_W-1:0]   ya, yb;
  logic [CNT_W-1:0] w, h;

  always_comb begin
    xa = (x0 > MX) ? MX : x0;
    xb = (x1 > MX) ? MX : x1;
    ya = (y0 > MY) ? MY : y0;
    yb = (y1 > MY) ? MY : y1;
    xs = (xa > xb) ? xb : xa;
    xe = (xa > xb) ? xa : xb;
    ys = (ya > yb) ? yb : ya;
    ye = (ya > yb) ? ya : yb;
    // Widened before subtracting so the full-screen product fits without overflow.
    w       = CNT_W'(xe) - CNT_W'(xs) + CNT_W'(1);
    h       = CNT_W'(ye) - CNT_W'(ys) + CNT_W'(1);
    pix_cnt = w * h;
  end

endmodule

// File: rtl/lcd_rect_fill_seq.sv
// Sequences spi_ctrl through CASET/PASET/RAMWR and the pixel stream for one solid rectangle.
module lcd_rect_fill_seq
  import lcd_pkg::*;
#(
  parameter int X_W   = 9,
  parameter int Y_W   = 9,
  parameter int MAX_X = 319,
  parameter int MAX_Y = 239,
  parameter int CNT_W = 17
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y1,
  input  logic [15:0]    color,
  input  logic           abort,
  output logic           spi_start,
  input  logic           spi_done,
  output logic [7:0]     spi_data,
  output logic           spi_dc,
  output logic           busy,
  output logic           fill_done
);

  fill_state_t      state;
  logic [X_W-1:0]   xs_q, xe_q, n_xs, n_xe;
  logic [Y_W-1:0]   ys_q, ye_q, n_ys, n_ye;
  logic [15:0]      color_q;
  logic [CNT_W-1:0] pix_cnt, n_cnt;
  logic             abort_pend;
  logic             adv;

  rect_norm #(
    .X_W(X_W), .Y_W(Y_W), .MAX_X(MAX_X), .MAX_Y(MAX_Y), .CNT_W(CNT_W)
  ) u_norm (
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .xs(n_xs), .xe(n_xe), .ys(n_ys), .ye(n_ye),
    .pix_cnt(n_cnt)
  );

  assign adv       = en && spi_done;
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign spi_start = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      xs_q       <= '0;
      xe_q       <= '0;
      ys_q       <= '0;
      ye_q       <= '0;
      color_q    <= '0;
      pix_cnt    <= '0;
      abort_pend <= 1'b0;
      fill_done  <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      if (state == IDLE) begin
        abort_pend <= 1'b0;
        if (req_valid) begin
          xs_q    <= n_xs;
          xe_q    <= n_xe;
          ys_q    <= n_ys;
          ye_q    <= n_ye;
          color_q <= color;
          pix_cnt <= n_cnt;
          state   <= S_CASET;
        end
      end else begin
        if (abort) abort_pend <= 1'b1;
        if (adv) begin
          // Last pixel and abort both end on a byte boundary with a single pulse.
          if ((state == PIX_L && pix_cnt == CNT_W'(1)) || abort || abort_pend) begin
            state      <= IDLE;
            fill_done  <= 1'b1;
            abort_pend <= 1'b0;
          end else if (state == PIX_L) begin
            pix_cnt <= pix_cnt - CNT_W'(1);
            state   <= PIX_H;
          end else begin
            state <= fill_state_t'(state + 4'd1);
          end
        end
      end
    end
  end

  always_comb begin
    spi_data = 8'h00;
    spi_dc   = 1'b1;
    case (state)
      IDLE:    spi_dc = 1'b0;
      S_CASET: begin spi_data = ILI_CASET; spi_dc = 1'b0; end
      S_PASET: begin spi_data = ILI_PASET; spi_dc = 1'b0; end
      S_RAMWR: begin spi_data = ILI_RAMWR; spi_dc = 1'b0; end
      XS_H:    spi_data = hi_byte(16'(xs_q));
      XS_L:    spi_data = lo_byte(16'(xs_q));
      XE_H:    spi_data = hi_byte(16'(xe_q));
      XE_L:    spi_data = lo_byte(16'(xe_q));
      YS_H:    spi_data = hi_byte(16'(ys_q));
      YS_L:    spi_data = lo_byte(16'(ys_q));
      YE_H:    spi_data = hi_byte(16'(ye_q));
      YE_L:    spi_data = lo_byte(16'(ye_q));
      PIX_H:   spi_data = hi_byte(color_q);
      PIX_L:   spi_data = lo_byte(color_q);
      default: begin spi_data = 8'h00; spi_dc = 1'b0; end
    endcase
  end

endmodule

// File: tb/tb_lcd_rect_fill_seq.sv
// Bench for lcd_rect_fill_seq: byte-stream scoreboard against a rectangle-level model.
module tb_lcd_rect_fill_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [8:0] x0 = '0, x1 = '0, y0 = '0, y1 = '0;
  logic [15:0] color = '0;
  logic       abort = 1'b0;
  logic       spi_start;
  logic       spi_done = 1'b0;
  logic [7:0] spi_data;
  logic       spi_dc;
  logic       busy;
  logic       fill_done;

  lcd_rect_fill_seq dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color), .abort(abort),
    .spi_start(spi_start), .spi_done(spi_done), .spi_data(spi_data), .spi_dc(spi_dc),
    .busy(busy), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  bit pending = 0;
  bit hold_en = 0;
  logic [8:0] cap[$];
  logic [8:0] exp_q[$];

  typedef struct {
    int x0, x1, y0, y1, col;
    int xs, xe, ys, ye, pix;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock: choose en, model spi_ctrl (done one en-cycle after start), capture completed bytes.
  task automatic step();
    en = hold_en ? 1'b0 : ($urandom_range(0, 3) != 0);
    spi_done = pending;
    if (en && spi_done) begin
      if (spi_start) cap.push_back({spi_dc, spi_data});
      pending = 0;
    end else if (en && spi_start) begin
      pending = 1;
    end
    @(negedge clk);
    if (fill_done) done_cnt++;
  endtask

  task automatic run_until_idle(input string nm);
    int n = 0;
    while (busy && n < 20000) begin step(); n++; end
    chk(!busy, {nm, " timeout"}, n, 20000);
  endtask

  task automatic start_req(input int a, input int b, input int c, input int d, input int col);
    x0 = 9'(a); x1 = 9'(b); y0 = 9'(c); y1 = 9'(d); color = 16'(col);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  // Expected stream from an already-normalised rectangle.
  task automatic build_exp(input int xs, input int xe, input int ys, input int ye,
                           input int col, input int pix);
    exp_q.delete();
    exp_q.push_back(9'h02A);
    exp_q.push_back({1'b1, 8'(xs / 256)}); exp_q.push_back({1'b1, 8'(xs % 256)});
    exp_q.push_back({1'b1, 8'(xe / 256)}); exp_q.push_back({1'b1, 8'(xe % 256)});
    exp_q.push_back(9'h02B);
    exp_q.push_back({1'b1, 8'(ys / 256)}); exp_q.push_back({1'b1, 8'(ys % 256)});
    exp_q.push_back({1'b1, 8'(ye / 256)}); exp_q.push_back({1'b1, 8'(ye % 256)});
    exp_q.push_back(9'h02C);
    for (int p = 0; p < pix; p++) begin
      exp_q.push_back({1'b1, 8'(col / 256)});
      exp_q.push_back({1'b1, 8'(col % 256)});
    end
  endtask

  // Reference: clamp, order, count, then emit the stream.
  task automatic model(input int a, input int b, input int c, input int d, input int col);
    int xa, xb, ya, yb, xs, xe, ys, ye;
    xa = (a > 319) ? 319 : a;  xb = (b > 319) ? 319 : b;
    ya = (c > 239) ? 239 : c;  yb = (d > 239) ? 239 : d;
    xs = (xa < xb) ? xa : xb;  xe = (xa < xb) ? xb : xa;
    ys = (ya < yb) ? ya : yb;  ye = (ya < yb) ? yb : ya;
    build_exp(xs, xe, ys, ye, col, (xe - xs + 1) * (ye - ys + 1));
  endtask

  task automatic cmp_stream(input string nm);
    int bad_i = -1;
    int n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (cap[i] !== exp_q[i] && bad_i < 0) bad_i = i;
    chk(cap.size() == exp_q.size(), {nm, " length"}, cap.size(), exp_q.size());
    chk(bad_i < 0, $sformatf("%s byte[%0d]", nm, bad_i),
        (bad_i < 0) ? 0 : int'(cap[bad_i]), (bad_i < 0) ? 0 : int'(exp_q[bad_i]));
  endtask

  initial begin
    logic [8:0] exp1 [13];
    int d0, n, hold_data, hold_sz, stable, starts;

    exp1 = '{9'h02A, 9'h100, 9'h105, 9'h100, 9'h105, 9'h02B, 9'h100, 9'h107,
             9'h100, 9'h107, 9'h02C, 9'h1F8, 9'h100};
    tbl[0] = '{x0:5,   x1:5,   y0:7,   y1:7,   col:'hF800, xs:5,   xe:5,   ys:7,   ye:7,   pix:1};
    tbl[1] = '{x0:400, x1:10,  y0:3,   y1:3,   col:'h1234, xs:10,  xe:319, ys:3,   ye:3,   pix:310};
    tbl[2] = '{x0:300, x1:350, y0:250, y1:230, col:'hABCD, xs:300, xe:319, ys:230, ye:239, pix:200};
    tbl[3] = '{x0:257, x1:256, y0:1,   y1:0,   col:'h00FF, xs:256, xe:257, ys:0,   ye:1,   pix:4};

    // Reset values
    @(negedge clk); @(negedge clk);
    chk(req_ready == 1'b1 && busy == 1'b0, "reset ready/busy", {req_ready, busy}, 2'b10);
    chk(spi_start == 1'b0 && fill_done == 1'b0, "reset start/done", {spi_start, fill_done}, 0);
    chk(spi_data == 8'h00 && spi_dc == 1'b0, "reset data/dc", {spi_dc, spi_data}, 0);
    rst_n = 1'b1;

    // 1x1 fill against the literal byte/dc stream
    cap.delete(); d0 = done_cnt;
    start_req(5, 5, 7, 7, 'hF800);
    run_until_idle("1x1");
    chk(cap.size() == 13, "1x1 length", cap.size(), 13);
    for (int i = 0; i < 13 && i < cap.size(); i++)
      chk(cap[i] === exp1[i], $sformatf("1x1 byte[%0d]", i), cap[i], exp1[i]);
    chk(done_cnt - d0 == 1, "1x1 fill_done", done_cnt - d0, 1);

    // Table vectors with hand-normalised expectations
    foreach (tbl[k]) begin
      cap.delete(); d0 = done_cnt;
      start_req(tbl[k].x0, tbl[k].x1, tbl[k].y0, tbl[k].y1, tbl[k].col);
      run_until_idle($sformatf("tbl%0d", k));
      build_exp(tbl[k].xs, tbl[k].xe, tbl[k].ys, tbl[k].ye, tbl[k].col, tbl[k].pix);
      cmp_stream($sformatf("tbl%0d", k));
      chk(done_cnt - d0 == 1, $sformatf("tbl%0d fill_done", k), done_cnt - d0, 1);
    end

    // Randomised small rectangles, some straddling the clamp limits
    for (int r = 0; r < 8; r++) begin
      int a, b, c, d, col;
      a = $urandom_range(0, 400); b = a + $urandom_range(0, 6) - 3; if (b < 0) b = 0;
      c = $urandom_range(0, 260); d = c + $urandom_range(0, 6) - 3; if (d < 0) d = 0;
      col = $urandom_range(0, 65535);
      cap.delete(); d0 = done_cnt;
      start_req(a, b, c, d, col);
      run_until_idle($sformatf("rnd%0d", r));
      model(a, b, c, d, col);
      cmp_stream($sformatf("rnd%0d", r));
      chk(done_cnt - d0 == 1, $sformatf("rnd%0d fill_done", r), done_cnt - d0, 1);
    end

    // Abort during the 3rd pixel byte of a 4x4 fill
    cap.delete(); d0 = done_cnt;
    start_req(20, 23, 30, 33, 'h5A5A);
    n = 0;
    while (cap.size() < 13 && n < 2000) begin step(); n++; end
    abort = 1'b1;
    step();
    abort = 1'b0;
    run_until_idle("abort");
    chk(cap.size() == 14, "abort bytes sent", cap.size(), 14);
    chk(done_cnt - d0 == 1, "abort fill_done", done_cnt - d0, 1);
    starts = 0;
    repeat (20) begin step(); if (spi_start) starts++; end
    chk(starts == 0, "abort no further start", starts, 0);

    // en held low 20 cycles with spi_done high, then resume
    cap.delete(); d0 = done_cnt;
    start_req(10, 11, 20, 21, 'h0F0F);
    n = 0;
    while (!(cap.size() >= 5 && pending) && n < 2000) begin step(); n++; end
    hold_en = 1; hold_data = spi_data; hold_sz = cap.size(); stable = 1;
    repeat (20) begin step(); if (spi_data != 8'(hold_data) || !spi_done) stable = 0; end
    chk(stable == 1, "en-low data stable", stable, 1);
    chk(cap.size() == hold_sz, "en-low no advance", cap.size(), hold_sz);
    hold_en = 0;
    run_until_idle("en-low");
    model(10, 11, 20, 21, 'h0F0F);
    cmp_stream("en-low");

    // req_valid held across completion: next request one clk after fill_done
    cap.delete();
    x0 = 9'd2; x1 = 9'd3; y0 = 9'd4; y1 = 9'd4; color = 16'h1111;
    req_valid = 1'b1;
    n = 0;
    step();
    while (!fill_done && n < 2000) begin step(); n++; end
    chk(fill_done && req_ready && !busy, "b2b idle at done", {fill_done, req_ready, busy}, 3'b110);
    model(2, 3, 4, 4, 'h1111);
    cmp_stream("b2b first");
    cap.delete(); d0 = done_cnt;
    x0 = 9'd100; x1 = 9'd100; y0 = 9'd200; y1 = 9'd201; color = 16'h2222;
    step();
    req_valid = 1'b0;
    chk(busy && spi_start && spi_data == 8'h2A && !spi_dc, "b2b second accept",
        {busy, spi_start, spi_dc, spi_data}, {3'b110, 8'h2A});
    run_until_idle("b2b");
    model(100, 100, 200, 201, 'h2222);
    cmp_stream("b2b second");
    chk(done_cnt - d0 == 1, "b2b fill_done", done_cnt - d0, 1);

    // Asynchronous reset mid-PASET
    cap.delete(); d0 = done_cnt;
    start_req(50, 52, 60, 61, 'h7777);
    n = 0;
    while (cap.size() < 7 && n < 2000) begin step(); n++; end
    #2 rst_n = 1'b0;
    #1;
    chk(!busy && !spi_start && req_ready && !fill_done, "async reset ctl",
        {busy, spi_start, req_ready, fill_done}, 4'b0010);
    chk(spi_data == 8'h00 && spi_dc == 1'b0, "async reset data", {spi_dc, spi_data}, 0);
    @(negedge clk);
    rst_n = 1'b1; pending = 0;
    chk(done_cnt == d0 && !fill_done, "async reset no pulse", done_cnt - d0, 0);
    cap.delete(); d0 = done_cnt;
    start_req(1, 0, 2, 2, 'hF800);
    run_until_idle("post-reset");
    model(1, 0, 2, 2, 'hF800);
    cmp_stream("post-reset");
    chk(done_cnt - d0 == 1, "post-reset fill_done", done_cnt - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_rect_fill_seq.md
Name: lcd_rect_fill_seq

Overview:
- Controller that sequences the SPI byte engine (spi_ctrl start/done/data_in handshake) to fill one rectangle on the ILI9341 with a solid RGB565 colour.
- Issues CASET (0x2A) with 4 data bytes, then PASET (0x2B) with 4 data bytes, then RAMWR (0x2C) followed by 2 bytes per pixel.
- Sits between a request source (init sequencer or host logic) and spi_ctrl. Drives the byte value, the dc line and spi start.

Parameters:
- X_W, 9, width of the column coordinate.
- Y_W, 9, width of the row coordinate.
- MAX_X, 319, largest legal column; larger inputs are clamped.
- MAX_Y, 239, largest legal row; larger inputs are clamped.
- CNT_W, 17, pixel counter width; must satisfy (MAX_X+1)*(MAX_Y+1) < 2^CNT_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  byte-rate strobe (spi_clk_phase data_clk_en); gates all byte advances
- req_valid  in  1  rectangle request
- req_ready  out  1  high in IDLE; the request is accepted on req_valid&&req_ready
- x0,x1  in  X_W  column bounds, inclusive
- y0,y1  in  Y_W  row bounds, inclusive
- color  in  16  RGB565 fill colour
- abort  in  1  terminate the current fill at the next byte boundary
- spi_start  out  1  to spi_ctrl start
- spi_done  in  1  from spi_ctrl done
- spi_data  out  8  to spi_ctrl data_in
- spi_dc  out  1  LCD D/C line: 0 = command, 1 = data
- busy  out  1  state != IDLE
- fill_done  out  1  one-clk pulse when a fill completes or abort completes

Behaviour:
- Reset (asynchronous):
  - state=IDLE, all latched registers 0.
  - spi_start=0, spi_data=0x00, spi_dc=0, busy=0, fill_done=0, req_ready=1.
- Accept: on any clk edge where req_valid && state==IDLE (not gated by en), the block:
  - clamps each coordinate to MAX_X / MAX_Y;
  - swaps a pair whose start is greater than its end;
  - latches xs, xe, ys, ye and color;
  - loads pix_cnt = (xe-xs+1)*(ye-ys+1), computed at CNT_W bits with no overflow;
  - moves to S_CASET.
- States, in order: IDLE, S_CASET, XS_H, XS_L, XE_H, XE_L, S_PASET, YS_H, YS_L, YE_H, YE_L, S_RAMWR, PIX_H, PIX_L.
- Advance: a byte state moves to the next state only on a cycle with en && spi_done. No advance occurs when en=0.
- Coordinate bytes are 16-bit big-endian and zero-extended: XS_H={7'b0,xs[8]}, XS_L=xs[7:0]. The same pattern applies to xe, ys and ye.
- spi_data and spi_dc are combinational from state and latched registers, and hold stable for the whole byte.
  - Command states (S_CASET/S_PASET/S_RAMWR) output 0x2A/0x2B/0x2C with dc=0.
  - All other byte states output dc=1.
  - IDLE outputs 0x00 with dc=0.
- Pixel bytes: PIX_H drives color[15:8]; PIX_L drives color[7:0].
- Pixel loop on PIX_L advance:
  - if pix_cnt==1, go to IDLE and pulse fill_done;
  - otherwise decrement pix_cnt and go to PIX_H.
- spi_start=1 in every byte state and 0 in IDLE.
- abort:
  - Latched into abort_pend when busy. Ignored in IDLE.
  - At the next en && spi_done, the state goes to IDLE and fill_done pulses, so no partial byte is ever cut.
  - If abort arrives in the same cycle as the final PIX_L advance, it is a normal completion with a single fill_done pulse.
  - abort_pend clears on entry to IDLE.
- Back-to-back: fill_done and the return to IDLE happen on the same edge. req_ready rises in that cycle, so the next request can be accepted the following edge.
- Asynchronous reset mid-fill returns immediately to the reset values. No fill_done pulse is emitted.
- A 1x1 rectangle produces exactly 13 bytes. A full screen produces 11 + 153600 bytes.

Decomposition:
- Shared package lcd_pkg holds:
  - constants ILI_CASET=8'h2A, ILI_PASET=8'h2B, ILI_RAMWR=8'h2C, COLOR_RED=16'hF800;
  - LCD_W=320 and LCD_H=240;
  - the state encoding localparams.
- One sub-module, rect_norm: a combinational clamp/swap plus pixel-count multiply, so it can be reused by a future scroll/blit controller.
- Everything else is in one FSM with a pix_cnt counter.

Test Plan:
- 1x1 fill at (5,7), color=F800, spi_done model returning done one en-cycle after start:
  - expect the byte stream 2A,00,05,00,05,2B,00,07,00,07,2C,F8,00;
  - dc pattern 0,1,1,1,1,0,1,1,1,1,0,1,1;
  - one fill_done pulse.
- Inverted and out-of-range request x0=400,x1=10,y0=3,y1=3:
  - CASET data is 00,0A,01,3F;
  - 310 pixels, giving 620 pixel bytes.
- abort asserted during the 3rd pixel byte of a 4x4 fill:
  - the current byte completes;
  - the state returns to IDLE at that en&&spi_done;
  - fill_done pulses;
  - no further spi_start.
- en held low for 20 cycles mid-fill with spi_done=1: no state change and spi_data is stable. Resume gives the correct next byte.
- req_valid held high across completion: the second request is accepted one clk after fill_done, and its first byte is 2A.
- rst_n asserted asynchronously mid-PASET: all outputs are at reset values before the next clk edge. A new request afterwards starts cleanly.
